// File: rtl/config_pkg.sv
// Shared configuration for the fetch front end: machine widths, the
// control-flow classification handed to the instruction queue, the fetch
// FSM state encoding, base opcodes and immediate decode helpers.
package config_pkg;

    localparam int XLEN = 32;
    localparam int VLEN = 32;

    typedef enum logic [2:0] {
        NoCF,
        Branch,
        Jump,
        JumpR,
        Return
    } cf_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        HOLD
    } fetch_state_e;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // J-type immediate, sign-extended to VLEN
    function automatic logic [VLEN-1:0] imm_j(input logic [31:0] instr);
        return {{(VLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    // B-type immediate, sign-extended to VLEN
    function automatic logic [VLEN-1:0] imm_b(input logic [31:0] instr);
        return {{(VLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Static predecoder: classifies one 32-bit instruction and predicts the
// next fetch address. Backward branches are predicted taken, forward
// branches not taken; indirect jumps fall through to pc+4.
module fetch_predecode
    import config_pkg::*;
(
    input  logic [31:0]     instr,
    input  logic [VLEN-1:0] pc,
    output cf_t             cf_type,
    output logic [VLEN-1:0] predict_address
);

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       unused_funct3;

    assign opcode        = instr[6:0];
    assign rd            = instr[11:7];
    assign rs1           = instr[19:15];
    assign unused_funct3 = ^instr[14:12];

    // Classify by opcode; all address arithmetic wraps modulo 2^VLEN
    always_comb begin
        cf_type         = NoCF;
        predict_address = pc + VLEN'(4);
        case (opcode)
            OPC_JAL: begin
                cf_type         = Jump;
                predict_address = pc + imm_j(instr);
            end
            OPC_BRANCH: begin
                cf_type = Branch;
                if (instr[31]) begin
                    predict_address = pc + imm_b(instr);
                end
            end
            OPC_JALR: begin
                if (rd == 5'd0 && (rs1 == 5'd1 || rs1 == 5'd5)) begin
                    cf_type = Return;
                end else begin
                    cf_type = JumpR;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the fetch PC, keeps exactly one instruction-cache
// request in flight, registers the returned instruction and offers it on
// the instruction-queue push interface until it is consumed or replayed.
// Static prediction is built only when FETCH_STATIC_PREDICT_EN is defined;
// otherwise every entry is NoCF with a pc+4 prediction.
module fetch_ctrl
    import config_pkg::*;
#(
    parameter logic [VLEN-1:0] BOOT_ADDR = VLEN'('h8000_0000)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic [VLEN-1:0] flush_pc_i,
    output logic            icache_req_valid_o,
    input  logic            icache_req_ready_i,
    output logic [VLEN-1:0] icache_req_addr_o,
    output logic            icache_kill_o,
    input  logic            icache_rsp_valid_i,
    input  logic [31:0]     icache_rsp_data_i,
    output logic            valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [VLEN-1:0] addr_o,
    output cf_t             cf_type_o,
    output logic [VLEN-1:0] predict_address_o,
    input  logic            ready_i,
    input  logic            consumed_i,
    input  logic            replay_i,
    input  logic [VLEN-1:0] replay_addr_i
);

    fetch_state_e    state_q, state_d;
    logic [VLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q;
    logic [VLEN-1:0] addr_q;
    logic            capture;
    cf_t             pred_cf;
    logic [VLEN-1:0] pred_addr;
    logic            unused_ready;

    // The entry is held until consumed or replayed, so queue-full is not needed here
    assign unused_ready = ready_i;

`ifdef FETCH_STATIC_PREDICT_EN
    fetch_predecode u_predecode (
        .instr           (instr_q),
        .pc              (addr_q),
        .cf_type         (pred_cf),
        .predict_address (pred_addr)
    );
`else
    assign pred_cf   = NoCF;
    assign pred_addr = addr_q + VLEN'(4);
`endif

    // State, fetch PC and the registered instruction/PC pair
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= BOOT_ADDR;
            instr_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (capture) begin
                instr_q <= icache_rsp_data_i;
                addr_q  <= pc_q;
            end
        end
    end

    // Next state, next PC and cache handshake; flush beats replay beats consume.
    // A flush in the same cycle the cache accepts a request leaves that request
    // outstanding, so it is killed and drained exactly like a flush in WAIT.
    always_comb begin
        state_d            = state_q;
        pc_d               = pc_q;
        capture            = 1'b0;
        icache_req_valid_o = 1'b0;
        icache_kill_o      = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (flush_i) begin
                    pc_d = flush_pc_i;
                end
            end
            REQ: begin
                icache_req_valid_o = 1'b1;
                if (flush_i) begin
                    pc_d = flush_pc_i;
                    if (icache_req_ready_i) begin
                        icache_kill_o = 1'b1;
                        state_d       = DRAIN;
                    end
                end else if (icache_req_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (flush_i) begin
                    pc_d = flush_pc_i;
                    if (icache_rsp_valid_i) begin
                        state_d = REQ;
                    end else begin
                        icache_kill_o = 1'b1;
                        state_d       = DRAIN;
                    end
                end else if (icache_rsp_valid_i) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            DRAIN: begin
                if (flush_i) begin
                    pc_d = flush_pc_i;
                end
                if (icache_rsp_valid_i) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (flush_i) begin
                    pc_d    = flush_pc_i;
                    state_d = REQ;
                end else if (replay_i) begin
                    pc_d    = replay_addr_i;
                    state_d = REQ;
                end else if (consumed_i) begin
                    pc_d    = pred_addr;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign icache_req_addr_o = pc_q;
    assign valid_o           = (state_q == HOLD);
    assign instr_o           = XLEN'(instr_q);
    assign addr_o            = addr_q;
    assign cf_type_o         = valid_o ? pred_cf : NoCF;
    assign predict_address_o = valid_o ? pred_addr : '0;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a behavioural cache, a transaction
// level model of the fetch front end, a predecode vector table and a
// randomized run. Expectations follow FETCH_STATIC_PREDICT_EN.
module tb_fetch_ctrl;
    import config_pkg::*;

    localparam logic [31:0] BOOT = 32'h8000_0000;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            flush_i;
    logic [VLEN-1:0] flush_pc_i;
    logic            icache_req_valid_o;
    logic            icache_req_ready_i;
    logic [VLEN-1:0] icache_req_addr_o;
    logic            icache_kill_o;
    logic            icache_rsp_valid_i;
    logic [31:0]     icache_rsp_data_i;
    logic            valid_o;
    logic [XLEN-1:0] instr_o;
    logic [VLEN-1:0] addr_o;
    cf_t             cf_type_o;
    logic [VLEN-1:0] predict_address_o;
    logic            ready_i;
    logic            consumed_i;
    logic            replay_i;
    logic [VLEN-1:0] replay_addr_i;

    fetch_ctrl #(.BOOT_ADDR(BOOT)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .flush_i            (flush_i),
        .flush_pc_i         (flush_pc_i),
        .icache_req_valid_o (icache_req_valid_o),
        .icache_req_ready_i (icache_req_ready_i),
        .icache_req_addr_o  (icache_req_addr_o),
        .icache_kill_o      (icache_kill_o),
        .icache_rsp_valid_i (icache_rsp_valid_i),
        .icache_rsp_data_i  (icache_rsp_data_i),
        .valid_o            (valid_o),
        .instr_o            (instr_o),
        .addr_o             (addr_o),
        .cf_type_o          (cf_type_o),
        .predict_address_o  (predict_address_o),
        .ready_i            (ready_i),
        .consumed_i         (consumed_i),
        .replay_i           (replay_i),
        .replay_addr_i      (replay_addr_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    int checks = 0;
    int errors = 0;

    // Instruction memory: explicit words, else NOP or an address hash
    logic [31:0] mem_aa [logic [31:0]];
    bit          hash_mode;

    // Cache model
    bit          c_busy;
    int          c_cnt;
    logic [31:0] c_addr;
    int          lat_min, lat_max, ready_pct;

    // Fetch front-end model
    bit          m_idle, m_req, m_wait, m_drain, m_hold;
    logic [31:0] m_pc, m_epc, m_einstr;

    // Observations
    logic [31:0] req_log[$];
    int          entries;
    cf_t         first_cf;
    logic [31:0] first_pred;
    logic        last_kill;
    bit          any_valid;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        cf_t         cf;
        logic [31:0] pred;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [31:0] h;
        if (mem_aa.exists(a)) return mem_aa[a];
        if (!hash_mode) return 32'h0000_0013;
        h = a * 32'h9E37_79B1;
        h = h ^ (h >> 15);
        case (h[2:0])
            3'd2:    return {h[31:12], 5'd0, 7'h6F};
            3'd3:    return {h[31:25], h[24:20], h[19:15], 3'b001, h[11:7], 7'h63};
            3'd4:    return {12'd0, (h[3] ? 5'd1 : 5'd5), 3'b000, 5'd0, 7'h67};
            3'd5:    return {h[31:20], h[19:15], 3'b000, h[11:7], 7'h67};
            3'd6:    return {h[31:7], 7'h33};
            default: return 32'h0000_0013;
        endcase
    endfunction

    // Reference predecode from the instruction-set rules using integer arithmetic
    function automatic void refDecode(input logic [31:0] ins, input logic [31:0] pc,
                                      output cf_t cf, output logic [31:0] tgt);
        int opc, rd, rs1, imm;
        opc = int'(ins & 32'h7F);
        rd  = int'((ins >> 7) & 32'h1F);
        rs1 = int'((ins >> 15) & 32'h1F);
        cf  = NoCF;
        tgt = pc + 32'd4;
`ifdef FETCH_STATIC_PREDICT_EN
        if (opc == 'h6F) begin
            imm = ins[31] ? -(1 << 20) : 0;
            imm += int'((ins >> 12) & 32'hFF) * 4096;
            imm += int'((ins >> 20) & 32'h1) * 2048;
            imm += int'((ins >> 21) & 32'h3FF) * 2;
            cf  = Jump;
            tgt = pc + 32'(imm);
        end else if (opc == 'h63) begin
            imm = ins[31] ? -4096 : 0;
            imm += int'((ins >> 7) & 32'h1) * 2048;
            imm += int'((ins >> 25) & 32'h3F) * 32;
            imm += int'((ins >> 8) & 32'hF) * 2;
            cf  = Branch;
            if (imm < 0) tgt = pc + 32'(imm);
        end else if (opc == 'h67) begin
            cf = (rd == 0 && (rs1 == 1 || rs1 == 5)) ? Return : JumpR;
        end
`else
        imm = opc + rd + rs1;
`endif
    endfunction

    task automatic doReset();
        rst_i = 1'b1;
        flush_i = 1'b0; flush_pc_i = '0; icache_req_ready_i = 1'b0;
        icache_rsp_valid_i = 1'b0; icache_rsp_data_i = '0; ready_i = 1'b0;
        consumed_i = 1'b0; replay_i = 1'b0; replay_addr_i = '0;
        mem_aa.delete(); req_log.delete();
        c_busy = 0; c_cnt = 0; c_addr = '0;
        m_idle = 1; m_req = 0; m_wait = 0; m_drain = 0; m_hold = 0;
        m_pc = BOOT; m_epc = '0; m_einstr = '0;
        entries = 0; any_valid = 0;
        repeat (2) @(negedge clk_i);
        checkOutput("rst_req_valid", 64'(icache_req_valid_o), 64'd0);
        checkOutput("rst_kill", 64'(icache_kill_o), 64'd0);
        checkOutput("rst_valid", 64'(valid_o), 64'd0);
        checkOutput("rst_instr", 64'(instr_o), 64'd0);
        checkOutput("rst_addr", 64'(addr_o), 64'd0);
        checkOutput("rst_cf", 64'(cf_type_o), 64'(NoCF));
        checkOutput("rst_predict", 64'(predict_address_o), 64'd0);
        checkOutput("rst_req_addr", 64'(icache_req_addr_o), 64'(BOOT));
        rst_i = 1'b0;
    endtask

    // One cycle: check outputs against the model, drive inputs, advance the model
    task automatic applyStimulus(input logic fl, input logic [31:0] fpc, input logic rp,
                                 input logic [31:0] rpa, input logic cons);
        cf_t         ecf;
        logic [31:0] epred;
        logic        rsp, rdy, ekill;
        ecf = NoCF;
        epred = '0;
        checkOutput("req_valid", 64'(icache_req_valid_o), 64'(m_req));
        if (m_req) checkOutput("req_addr", 64'(icache_req_addr_o), 64'(m_pc));
        checkOutput("valid", 64'(valid_o), 64'(m_hold));
        if (valid_o) any_valid = 1;
        if (m_hold) begin
            refDecode(m_einstr, m_epc, ecf, epred);
            checkOutput("entry_addr", 64'(addr_o), 64'(m_epc));
            checkOutput("entry_instr", 64'(instr_o), 64'(m_einstr));
            checkOutput("entry_cf", 64'(cf_type_o), 64'(ecf));
            checkOutput("entry_predict", 64'(predict_address_o), 64'(epred));
            if (entries == 0) begin
                first_cf = cf_type_o;
                first_pred = predict_address_o;
            end
            entries++;
        end
        rsp = c_busy && c_cnt == 0;
        rdy = !c_busy && ($urandom_range(99) < 32'(ready_pct));
        flush_i = fl; flush_pc_i = fpc; replay_i = rp; replay_addr_i = rpa; consumed_i = cons;
        icache_req_ready_i = rdy;
        icache_rsp_valid_i = rsp;
        icache_rsp_data_i = rsp ? memWord(c_addr) : $urandom();
        ready_i = 1'($urandom_range(1));
        #1;
        ekill = fl && ((m_wait && !rsp) || (m_req && rdy));
        checkOutput("kill", 64'(icache_kill_o), 64'(ekill));
        last_kill = icache_kill_o;
        if (icache_req_valid_o && rdy) req_log.push_back(icache_req_addr_o);
        if (rsp) c_busy = 0;
        else if (c_busy) c_cnt--;
        if (m_req && rdy) begin
            c_busy = 1;
            c_cnt = int'($urandom_range(lat_max, lat_min)) - 1;
            c_addr = m_pc;
        end
        if (m_idle) begin
            m_idle = 0; m_req = 1;
            if (fl) m_pc = fpc;
        end else if (m_req) begin
            if (fl) begin
                m_pc = fpc;
                if (rdy) begin m_req = 0; m_drain = 1; end
            end else if (rdy) begin
                m_req = 0; m_wait = 1;
            end
        end else if (m_wait) begin
            if (fl) begin
                m_pc = fpc; m_wait = 0;
                if (rsp) m_req = 1; else m_drain = 1;
            end else if (rsp) begin
                m_wait = 0; m_hold = 1; m_epc = m_pc; m_einstr = icache_rsp_data_i;
            end
        end else if (m_drain) begin
            if (fl) m_pc = fpc;
            if (rsp) begin m_drain = 0; m_req = 1; end
        end else if (m_hold) begin
            if (fl || rp || cons) begin
                m_pc = fl ? fpc : (rp ? rpa : epred);
                m_hold = 0; m_req = 1;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic runUntilReqs(input int n, input logic cons, input logic rp, input logic [31:0] rpa);
        for (int k = 0; k < 80 && req_log.size() < n; k++) applyStimulus(1'b0, '0, rp, rpa, cons);
        checkOutput("req_count", 64'(req_log.size()), 64'(n));
    endtask

    task automatic runUntilValid();
        for (int k = 0; k < 80 && !valid_o; k++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("valid_reached", 64'(valid_o), 64'd1);
    endtask

    initial begin
        cf_t         exp_cf;
        logic [31:0] exp_pred;
        int          n0;

        vecs[0] = '{32'h0100006F, 32'h8000_0000, Jump,   32'h8000_0010};
        vecs[1] = '{32'hFE000EE3, 32'h8000_0020, Branch, 32'h8000_001C};
        vecs[2] = '{32'h00000863, 32'h8000_0020, Branch, 32'h8000_0024};
        vecs[3] = '{32'h00008067, 32'h8000_1000, Return, 32'h8000_1004};
        vecs[4] = '{32'h00028067, 32'h8000_1100, Return, 32'h8000_1104};
        vecs[5] = '{32'h000300E7, 32'h8000_1200, JumpR,  32'h8000_1204};
        vecs[6] = '{32'h00008167, 32'h8000_1300, JumpR,  32'h8000_1304};
        vecs[7] = '{32'hFF9FF06F, 32'h0000_0004, Jump,   32'hFFFF_FFFC};
        vecs[8] = '{32'h00000463, 32'hFFFF_FFFC, Branch, 32'h0000_0000};
        vecs[9] = '{32'h002081B3, 32'h8000_2000, NoCF,   32'h8000_2004};

        hash_mode = 0;

        // Straight-line NOP fetch, 2-cycle cache, queue always consumes
        lat_min = 2; lat_max = 2; ready_pct = 100;
        doReset();
        runUntilReqs(3, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++)
            if (req_log.size() > i) checkOutput("straight_req", 64'(req_log[i]), 64'(BOOT + 32'(4 * i)));

        // JAL at the boot address
        doReset();
        mem_aa[BOOT] = 32'h0100006F;
        runUntilReqs(2, 1'b1, 1'b0, '0);
`ifdef FETCH_STATIC_PREDICT_EN
        exp_cf = Jump;  exp_pred = 32'h8000_0010;
`else
        exp_cf = NoCF;  exp_pred = 32'h8000_0004;
`endif
        checkOutput("jal_cf", 64'(first_cf), 64'(exp_cf));
        checkOutput("jal_predict", 64'(first_pred), 64'(exp_pred));
        if (req_log.size() > 1) checkOutput("jal_next_req", 64'(req_log[1]), 64'(exp_pred));

        // Predecode table: flush to each vector, check the entry, consume, check the next request
        for (int i = 0; i < 10; i++) begin
`ifdef FETCH_STATIC_PREDICT_EN
            exp_cf = vecs[i].cf;  exp_pred = vecs[i].pred;
`else
            exp_cf = NoCF;        exp_pred = vecs[i].pc + 32'd4;
`endif
            mem_aa[vecs[i].pc] = vecs[i].ins;
            applyStimulus(1'b1, vecs[i].pc, 1'b0, '0, 1'b0);
            runUntilValid();
            checkOutput("vec_addr", 64'(addr_o), 64'(vecs[i].pc));
            checkOutput("vec_cf", 64'(cf_type_o), 64'(exp_cf));
            checkOutput("vec_predict", 64'(predict_address_o), 64'(exp_pred));
            n0 = req_log.size();
            applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
            runUntilReqs(n0 + 1, 1'b0, 1'b0, '0);
            if (req_log.size() > n0) checkOutput("vec_next_req", 64'(req_log[n0]), 64'(exp_pred));
        end

        // Replay held high (with consume) refetches the replay address
        doReset();
        runUntilValid();
        n0 = req_log.size();
        runUntilReqs(n0 + 1, 1'b1, 1'b1, 32'h8000_0040);
        if (req_log.size() > n0) checkOutput("replay_req", 64'(req_log[n0]), 64'h8000_0040);
        runUntilValid();
        checkOutput("replay_entry_addr", 64'(addr_o), 64'h8000_0040);

        // Flush while waiting on a slow response
        lat_min = 4; lat_max = 4;
        doReset();
        runUntilReqs(1, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 32'h9000_0000, 1'b0, '0, 1'b0);
        checkOutput("flush_kill", 64'(last_kill), 64'd1);
        any_valid = 0;
        runUntilReqs(2, 1'b0, 1'b0, '0);
        checkOutput("flush_no_stale", 64'(any_valid), 64'd0);
        if (req_log.size() > 1) checkOutput("flush_req", 64'(req_log[1]), 64'h9000_0000);
        runUntilValid();
        checkOutput("flush_entry_addr", 64'(addr_o), 64'h9000_0000);

        // Randomized traffic against the model
        lat_min = 1; lat_max = 4; ready_pct = 60; hash_mode = 1;
        doReset();
        for (int k = 0; k < 3000; k++) begin
            logic        fl, rp, cons;
            logic [31:0] fpc, rpa;
            fl   = ($urandom_range(19) == 0);
            fpc  = $urandom() & 32'hFFFF_FFFC;
            rp   = ($urandom_range(7) == 0);
            rpa  = $urandom() & 32'hFFFF_FFFC;
            cons = 1'($urandom_range(1));
            applyStimulus(fl, fpc, rp, rpa, cons);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
